// File: rtl/quad_step_decoder.sv
// Quadrature (A/B) decoder with per-channel synchronizer and glitch filter.
// Emits one registered step pulse per accepted edge (x4), err on illegal jumps.
module quad_step_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       en,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  state_t     state_r, state_nxt_s;
  logic       a_s1_r, a_s2_r, b_s1_r, b_s2_r;
  logic       a_filt_r, b_filt_r, a_filt_nxt_s, b_filt_nxt_s;
  logic [3:0] a_cnt_r, b_cnt_r, a_cnt_nxt_s, b_cnt_nxt_s;
  logic [1:0] prev_r, pair_s, diff_s;
  logic [1:0] prime_r;
  logic       step_r, err_r, dir_r;
  logic       step_nxt_s, err_nxt_s, dir_nxt_s;
  logic [3:0] err_cnt_r, err_cnt_nxt_s;
  logic       live_s;

  // Returns {filtered, counter} for the next cycle of one channel's filter.
  function automatic logic [4:0] filt_next(input logic s2, input logic filt,
                                           input logic [3:0] cnt);
    logic [4:0] res;
    if (s2 != filt) begin
      if (cnt == CNT_LAST) begin
        res = {~filt, 4'd0};
      end else begin
        res = {filt, cnt + 4'd1};
      end
    end else begin
      res = {filt, 4'd0};
    end
    return res;
  endfunction

  // Filter next-state for both channels.
  always_comb begin
    {a_filt_nxt_s, a_cnt_nxt_s} = filt_next(a_s2_r, a_filt_r, a_cnt_r);
    {b_filt_nxt_s, b_cnt_nxt_s} = filt_next(b_s2_r, b_filt_r, b_cnt_r);
  end

  assign pair_s = {a_filt_r, b_filt_r};
  assign diff_s = pair_s ^ prev_r;
  assign live_s = (state_r == TRACK) && en;

  // Edge decode: one bit changed is a step, both bits changed is an error.
  always_comb begin
    step_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    dir_nxt_s     = dir_r;
    err_cnt_nxt_s = err_cnt_r;
    if (live_s) begin
      step_nxt_s = (diff_s == 2'b01) || (diff_s == 2'b10);
      err_nxt_s  = (diff_s == 2'b11);
    end else begin
      step_nxt_s = 1'b0;
      err_nxt_s  = 1'b0;
    end
    // Up when the old A differs from the new B (00->01->11->10->00).
    if (step_nxt_s) begin
      dir_nxt_s = ~(prev_r[1] ^ pair_s[0]);
    end else begin
      dir_nxt_s = dir_r;
    end
    if (err_nxt_s && (err_cnt_r != 4'hF)) begin
      err_cnt_nxt_s = err_cnt_r + 4'd1;
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // INIT waits until the synchronizer holds real samples and both filters are at rest.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT: begin
        if ((prime_r == 2'd2) && (a_cnt_r == 4'd0) && (b_cnt_r == 4'd0) &&
            (a_s2_r == a_filt_r) && (b_s2_r == b_filt_r)) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = INIT;
        end
      end
      TRACK:   state_nxt_s = TRACK;
      default: state_nxt_s = INIT;
    endcase
  end

  // All state: synchronizers, filters, previous pair, FSM and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_r    <= 1'b0;
      a_s2_r    <= 1'b0;
      b_s1_r    <= 1'b0;
      b_s2_r    <= 1'b0;
      a_filt_r  <= 1'b0;
      b_filt_r  <= 1'b0;
      a_cnt_r   <= 4'd0;
      b_cnt_r   <= 4'd0;
      prev_r    <= 2'b00;
      prime_r   <= 2'd0;
      state_r   <= INIT;
      step_r    <= 1'b0;
      err_r     <= 1'b0;
      dir_r     <= 1'b0;
      err_cnt_r <= 4'd0;
    end else begin
      a_s1_r    <= a_in;
      a_s2_r    <= a_s1_r;
      b_s1_r    <= b_in;
      b_s2_r    <= b_s1_r;
      a_filt_r  <= a_filt_nxt_s;
      b_filt_r  <= b_filt_nxt_s;
      a_cnt_r   <= a_cnt_nxt_s;
      b_cnt_r   <= b_cnt_nxt_s;
      prev_r    <= pair_s;
      if (prime_r != 2'd2) begin
        prime_r <= prime_r + 2'd1;
      end else begin
        prime_r <= prime_r;
      end
      state_r   <= state_nxt_s;
      step_r    <= step_nxt_s;
      err_r     <= err_nxt_s;
      dir_r     <= dir_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
    end
  end

  assign step    = step_r;
  assign err     = err_r;
  assign dir     = dir_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus queues expected pulses,
// a negedge monitor pops and compares each step/err pulse the DUT emits.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       en = 1'b1;
  logic       step, dir, err;
  logic [3:0] err_cnt;

  quad_step_decoder #(.FILT_LEN(4)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .en(en),
    .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic       dir;
    logic [3:0] cnt;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       m_dir = 1'b0;
  logic [3:0] m_cnt = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (step === 1'b1 || err === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, step, err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("kind", {30'd0, step, err}, e.is_err ? 32'd1 : 32'd2);
        chk("dir", {31'd0, dir}, {31'd0, e.dir});
        chk("err_cnt", {28'd0, err_cnt}, {28'd0, e.cnt});
        chk("latency", cyc, e.at);
      end
    end
  end

  // Change inputs just after an edge; queue the expected pulse if one is due.
  task automatic move(input logic a, input logic b, input bit expect_evt);
    exp_t e;
    @(posedge clk);
    #1;
    if (expect_evt) begin
      e.is_err = (a != a_in) && (b != b_in);
      if (e.is_err) begin
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end else begin
        m_dir = ~(a_in ^ b);
      end
      e.dir = m_dir;
      e.cnt = m_cnt;
      e.at  = cyc + 7;
      sb.push_back(e);
    end
    a_in = a;
    b_in = b;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // clean up sequence, then down sequence
    move(1'b0, 1'b1, 1'b1);
    move(1'b1, 1'b1, 1'b1);
    move(1'b1, 1'b0, 1'b1);
    move(1'b0, 1'b0, 1'b1);
    move(1'b1, 1'b0, 1'b1);
    move(1'b1, 1'b1, 1'b1);
    move(1'b0, 1'b1, 1'b1);
    move(1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("dir_hold", {31'd0, dir}, 32'd1);

    // 3-cycle glitch on A is rejected, a stable change is accepted
    @(posedge clk);
    #1 a_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_in = 1'b0;
    repeat (12) @(posedge clk);
    move(1'b1, 1'b0, 1'b1);
    move(1'b0, 1'b0, 1'b1);

    // disabled during 01->11, re-enabled for 11->10
    move(1'b0, 1'b1, 1'b1);
    #1 en = 1'b0;
    move(1'b1, 1'b1, 1'b0);
    #1 en = 1'b1;
    move(1'b1, 1'b0, 1'b1);
    move(1'b0, 1'b0, 1'b1);

    // illegal double transitions, counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) move(1'b1, 1'b1, 1'b1);
      else            move(1'b0, 1'b0, 1'b1);
    end
    #1;
    chk("err_cnt_sat", {28'd0, err_cnt}, 32'd15);

    // reset mid-filter with inputs at 11, then absorb and resume
    @(posedge clk);
    #1;
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_step", {31'd0, step}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_dir", {31'd0, dir}, 32'd0);
    chk("mid_rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    m_dir = 1'b0;
    m_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("absorb_err_cnt", {28'd0, err_cnt}, 32'd0);
    move(1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);

    chk("queue_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 Parameter FILT_LEN, default 4, number of consecutive clk cycles a synchronized input must differ from its filtered value before the filtered value changes (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_in  input  1  raw quadrature channel A; asynchronous to clk, may bounce.
REQ-005 b_in  input  1  raw quadrature channel B; asynchronous to clk, may bounce.
REQ-006 en  input  1  synchronous enable for step/err generation.
REQ-007 step  output  1  one-cycle pulse per accepted quadrature edge; drives a downstream 4-bit up/down counter's count event.
REQ-008 dir  output  1  direction of the most recent step: 0 = up, 1 = down (the downstream counter's convention).
REQ-009 err  output  1  one-cycle pulse on an illegal quadrature transition.
REQ-010 err_cnt  output  4  saturating count of err events since reset.

Function
REQ-011 a_in and b_in SHALL each pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each channel SHALL have its own filter: a counter that increments while s2 != filtered value and clears to 0 whenever s2 == filtered value.
REQ-013 The filtered value SHALL toggle, and its counter clear, on the edge where the counter would reach FILT_LEN.
REQ-014 The decoder SHALL register the previous filtered pair {A,B} and compare it with the current pair every cycle.
REQ-015 Sequence 00->01->11->10->00 SHALL be up (dir=0); the reverse sequence SHALL be down (dir=1); every single-bit change SHALL produce a step (x4 decoding).
REQ-016 A change of both filtered bits in the same cycle SHALL produce err, no step, and dir unchanged; the previous pair SHALL still update to the new pair.
REQ-017 step and err SHALL be registered, asserted for the cycle following the edge on which the filtered pair changed; with unbounced input first sampled into s1 on edge N, step is high in the cycle after edge N+FILT_LEN+2.
REQ-018 dir SHALL update on the same edge step asserts and hold until the next step.
REQ-019 When en=0, step and err SHALL be held 0 and err_cnt and dir SHALL not change; synchronizers, filters and previous-pair tracking SHALL keep running, so re-enabling never yields a spurious step.
REQ-020 err_cnt SHALL increment by 1 per err pulse and saturate at 15 (no wrap to 0).
REQ-021 The FSM SHALL have two states: INIT and TRACK.
REQ-022 In INIT, step and err SHALL be suppressed, but filters and previous pair SHALL update.
REQ-023 INIT SHALL go to TRACK on the first edge at which both filter counters are 0 and both s2 equal their filtered values; TRACK SHALL persist until reset.
REQ-024 Bounce shorter than FILT_LEN cycles SHALL produce no filtered change, no step and no err.

Reset
REQ-025 While reset=1: s1, s2, filtered values, filter counters and previous pair SHALL be 0; FSM SHALL be INIT; step=0, dir=0, err=0, err_cnt=0.
REQ-026 Reset asserted mid-operation SHALL clear all state immediately regardless of clk; a pending filter count SHALL be discarded.
REQ-027 After deassertion, inputs already at 11 SHALL be absorbed in INIT without step or err.

Verification
REQ-028 FILT_LEN=4, en=1: reset, settle at 00, then clean up sequence 01,11,10,00 held 10 cycles each -> 4 step pulses, dir=0, first step in cycle after edge N+6, err_cnt=0.
REQ-029 Same with down sequence 00,10,11,01,00 -> 4 step pulses with dir=1; dir stays 1 afterward.
REQ-030 a_in toggles for 3 cycles then returns to its original value -> no step, no err; a 4-cycle-stable change -> exactly one step.
REQ-031 From settled 00, drive a_in and b_in to 11 on the same edge -> one err pulse, no step, err_cnt=1; repeat 20 times -> err_cnt=15.
REQ-032 en=0 during 01->11 -> no step/err; en=1 then 11->10 -> exactly one step, dir=0.
REQ-033 Assert reset mid-filter with inputs at 11, release -> no step/err, outputs 0, FSM reaches TRACK; next 11->10 -> one step, dir=0.
